// File: rtl/branch_resolve_unit_if.sv
// Prediction/resolution bus between the fetch-side BTB/NPC logic and the EX-stage branch resolver.
// The slave modport is the resolver's view; the master modport is the pipeline/NPC side.
interface branch_resolve_unit_if #(
   parameter int IDX_W = 3,
   parameter int CNT_W = 32
);
   logic [1:0]       BranchFlags;
   logic [IDX_W-1:0] BranchIndex;
   logic             StallD;
   logic             FlushD;
   logic             StallE;
   logic             FlushE;
   logic [2:0]       BranchTypeE;
   logic [31:0]      Operand1E;
   logic [31:0]      Operand2E;
   logic [1:0]       BranchE;
   logic [IDX_W-1:0] BranchIndexE;
   logic [CNT_W-1:0] BranchCnt;
   logic [CNT_W-1:0] MissCnt;

   modport slave (
      input  BranchFlags, BranchIndex, StallD, FlushD, StallE, FlushE,
      input  BranchTypeE, Operand1E, Operand2E,
      output BranchE, BranchIndexE, BranchCnt, MissCnt
   );

   modport master (
      output BranchFlags, BranchIndex, StallD, FlushD, StallE, FlushE,
      output BranchTypeE, Operand1E, Operand2E,
      input  BranchE, BranchIndexE, BranchCnt, MissCnt
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: pipes the fetch prediction to EX and compares it with the real outcome.
// Define BRU_PERF_CNT_EN to build the resolved/mispredicted branch counters.
module branch_resolve_unit #(
   parameter int IDX_W = 3,
   parameter int CNT_W = 32
) (
   input  logic                  clk,
   input  logic                  CpuRst_n,
   branch_resolve_unit_if.slave  bus
);
   localparam logic [2:0] BT_NONE = 3'd0;
   localparam logic [2:0] BT_BEQ  = 3'd1;
   localparam logic [2:0] BT_BNE  = 3'd2;
   localparam logic [2:0] BT_BLT  = 3'd3;
   localparam logic [2:0] BT_BLTU = 3'd4;
   localparam logic [2:0] BT_BGE  = 3'd5;
   localparam logic [2:0] BT_BGEU = 3'd6;

   logic [1:0]       flags_d;
   logic [IDX_W-1:0] idx_d;
   logic [1:0]       flags_e;
   logic [IDX_W-1:0] idx_e;
   logic             taken;
   logic             is_branch;
   logic             hit;
   logic             pred;
   logic [1:0]       resolve;

   always_ff @(posedge clk or negedge CpuRst_n) begin
      if (!CpuRst_n) begin
         flags_d <= 2'b00;
         idx_d   <= '0;
      end else if (bus.FlushD) begin
         flags_d <= 2'b00;
         idx_d   <= '0;
      end else if (!bus.StallD) begin
         flags_d <= bus.BranchFlags;
         idx_d   <= bus.BranchIndex;
      end
   end

   always_ff @(posedge clk or negedge CpuRst_n) begin
      if (!CpuRst_n) begin
         flags_e <= 2'b00;
         idx_e   <= '0;
      end else if (bus.FlushE) begin
         flags_e <= 2'b00;
         idx_e   <= '0;
      end else if (!bus.StallE) begin
         flags_e <= flags_d;
         idx_e   <= idx_d;
      end
   end

   always_comb begin
      taken     = 1'b0;
      is_branch = 1'b1;
      case (bus.BranchTypeE)
         BT_BEQ:  taken = (bus.Operand1E == bus.Operand2E);
         BT_BNE:  taken = (bus.Operand1E != bus.Operand2E);
         BT_BLT:  taken = ($signed(bus.Operand1E) <  $signed(bus.Operand2E));
         BT_BLTU: taken = (bus.Operand1E <  bus.Operand2E);
         BT_BGE:  taken = ($signed(bus.Operand1E) >= $signed(bus.Operand2E));
         BT_BGEU: taken = (bus.Operand1E >= bus.Operand2E);
         default: is_branch = 1'b0;
      endcase
   end

   // Flags 10 (predict-taken without a BTB hit) collapses to a plain miss.
   assign hit  = flags_e[0];
   assign pred = flags_e[0] & flags_e[1];

   always_comb begin
      resolve = 2'b00;
      if (is_branch) begin
         if (!hit && taken)
            resolve = 2'b01;
         else if (hit && !pred && taken)
            resolve = 2'b10;
         else if (hit && pred && !taken)
            resolve = 2'b11;
      end
   end

   // Outputs are forced quiet while reset is held so a live branch type cannot leak a redirect.
   assign bus.BranchE      = CpuRst_n ? resolve : 2'b00;
   assign bus.BranchIndexE = CpuRst_n ? idx_e : '0;

`ifdef BRU_PERF_CNT_EN
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] miss_cnt;
   logic             count_en;

   assign count_en = is_branch & ~bus.StallE;

   always_ff @(posedge clk or negedge CpuRst_n) begin
      if (!CpuRst_n) begin
         branch_cnt <= '0;
         miss_cnt   <= '0;
      end else if (count_en) begin
         branch_cnt <= branch_cnt + 1'b1;
         if (resolve != 2'b00)
            miss_cnt <= miss_cnt + 1'b1;
      end
   end

   assign bus.BranchCnt = branch_cnt;
   assign bus.MissCnt   = miss_cnt;
`else
   assign bus.BranchCnt = '0;
   assign bus.MissCnt   = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus randomized bench for branch_resolve_unit against a cycle-level prediction model.
module tb_branch_resolve_unit;
   localparam int IDX_W = 3;
   localparam int CNT_W = 32;

   logic clk;
   logic CpuRst_n;
   int   checks;
   int   errors;

   logic [1:0]       m_fd, m_fe;
   logic [IDX_W-1:0] m_id, m_ie;
   logic [CNT_W-1:0] m_bcnt, m_mcnt;
   logic [CNT_W-1:0] cnt_before;

   branch_resolve_unit_if #(.IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

   branch_resolve_unit #(.IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .CpuRst_n (CpuRst_n),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] exp_cnt(input logic [31:0] v);
`ifdef BRU_PERF_CNT_EN
      return v;
`else
      return 32'd0;
`endif
   endfunction

   // Resolution code from the architectural rules: outcome vs. what fetch assumed.
   function automatic logic [1:0] model_code(input logic [2:0] bt, input logic [31:0] a,
                                             input logic [31:0] b, input logic [1:0] fl);
      bit tk;
      bit assumed_taken;
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (bt)
         3'd1: tk = (a == b);
         3'd2: tk = (a != b);
         3'd3: tk = (sa < sb);
         3'd4: tk = ({1'b0, a} < {1'b0, b});
         3'd5: tk = (sa >= sb);
         3'd6: tk = ({1'b0, a} >= {1'b0, b});
         default: return 2'b00;
      endcase
      assumed_taken = (fl == 2'b11);
      if (tk == assumed_taken) return 2'b00;
      if (fl[0] == 1'b0) return 2'b01;
      return tk ? 2'b10 : 2'b11;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cmp_all(input string tag);
      #1;
      chk({tag, "_branch"}, 32'(bus.BranchE),
          32'(model_code(bus.BranchTypeE, bus.Operand1E, bus.Operand2E, m_fe)));
      chk({tag, "_index"}, 32'(bus.BranchIndexE), 32'(m_ie));
      chk({tag, "_bcnt"}, bus.BranchCnt, exp_cnt(m_bcnt));
      chk({tag, "_mcnt"}, bus.MissCnt, exp_cnt(m_mcnt));
   endtask

   task automatic tick();
      @(posedge clk);
      if (CpuRst_n) begin
         if (bus.BranchTypeE inside {[3'd1:3'd6]} && !bus.StallE) begin
            m_bcnt++;
            if (model_code(bus.BranchTypeE, bus.Operand1E, bus.Operand2E, m_fe) != 2'b00)
               m_mcnt++;
         end
         if (bus.FlushE) begin
            m_fe = 2'b00; m_ie = '0;
         end else if (!bus.StallE) begin
            m_fe = m_fd; m_ie = m_id;
         end
         if (bus.FlushD) begin
            m_fd = 2'b00; m_id = '0;
         end else if (!bus.StallD) begin
            m_fd = bus.BranchFlags; m_id = bus.BranchIndex;
         end
      end
      #1;
   endtask

   task automatic model_reset();
      m_fd = 2'b00; m_fe = 2'b00; m_id = '0; m_ie = '0;
      m_bcnt = '0; m_mcnt = '0;
   endtask

   task automatic fetch(input logic [1:0] fl, input logic [IDX_W-1:0] ix);
      bus.BranchFlags = fl;
      bus.BranchIndex = ix;
   endtask

   task automatic ex(input logic [2:0] bt, input logic [31:0] a, input logic [31:0] b);
      bus.BranchTypeE = bt;
      bus.Operand1E   = a;
      bus.Operand2E   = b;
   endtask

   task automatic ctrl(input logic sd, input logic fd, input logic se, input logic fe);
      bus.StallD = sd; bus.FlushD = fd; bus.StallE = se; bus.FlushE = fe;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      model_reset();
      CpuRst_n = 1'b0;
      fetch(2'b00, '0);
      ctrl(0, 0, 0, 0);
      ex(3'd0, 32'd0, 32'd0);

      #3;
      chk("rst_branch", 32'(bus.BranchE), 32'd0);
      chk("rst_index", 32'(bus.BranchIndexE), 32'd0);
      chk("rst_bcnt", bus.BranchCnt, 32'd0);
      #5 CpuRst_n = 1'b1;
      tick();

      // BTB miss, branch taken
      fetch(2'b00, 3'd2);
      tick(); tick();
      ex(3'd1, 32'h5, 32'h5);
      #1 chk("miss_taken_code", 32'(bus.BranchE), 32'h1);
      cmp_all("miss_taken");
      tick();
      ex(3'd0, 32'h0, 32'h0);
      chk("miss_taken_mcnt", bus.MissCnt, exp_cnt(32'd1));
      chk("miss_taken_bcnt", bus.BranchCnt, exp_cnt(32'd1));

      // Hit, predicted taken, signed vs unsigned compare
      fetch(2'b11, 3'd3);
      tick(); tick();
      ex(3'd3, 32'h1, 32'hFFFF_FFFF);
      #1 chk("blt_code", 32'(bus.BranchE), 32'h3);
      chk("blt_index", 32'(bus.BranchIndexE), 32'h3);
      ex(3'd4, 32'h1, 32'hFFFF_FFFF);
      #1 chk("bltu_code", 32'(bus.BranchE), 32'h0);
      cmp_all("bltu");
      tick();

      // Hit, predicted not taken, actually taken
      ex(3'd0, 32'h0, 32'h0);
      fetch(2'b01, 3'd6);
      tick(); tick();
      ex(3'd2, 32'h2, 32'h3);
      #1 chk("bne_code", 32'(bus.BranchE), 32'h2);
      chk("bne_index", 32'(bus.BranchIndexE), 32'h6);
      tick();

      // Flush of ID/EX turns the arriving hit into a bubble
      ex(3'd0, 32'h0, 32'h0);
      fetch(2'b01, 3'd5);
      tick();
      ctrl(0, 0, 0, 1);
      tick();
      ctrl(0, 0, 0, 0);
      ex(3'd4, 32'h5, 32'h1);
      #1 chk("flushe_code", 32'(bus.BranchE), 32'h0);
      chk("flushe_index", 32'(bus.BranchIndexE), 32'h0);
      ex(3'd0, 32'h0, 32'h0);

      // Stalled resolving branch counts once
      fetch(2'b00, 3'd1);
      tick(); tick();
      cnt_before = m_bcnt;
      ctrl(0, 0, 1, 0);
      ex(3'd1, 32'h7, 32'h7);
      for (int i = 0; i < 3; i++) begin
         #1 chk("stall_code", 32'(bus.BranchE), 32'h1);
         tick();
      end
      chk("stall_hold_bcnt", bus.BranchCnt, exp_cnt(cnt_before));
      ctrl(0, 0, 0, 0);
      tick();
      ex(3'd0, 32'h0, 32'h0);
      chk("stall_once_bcnt", bus.BranchCnt, exp_cnt(cnt_before + 32'd1));

      // FlushD together with StallD: flush wins
      fetch(2'b10, 3'd4);
      tick();
      ctrl(1, 1, 0, 0);
      tick();
      ctrl(0, 0, 0, 0);
      fetch(2'b00, 3'd0);
      tick();
      ex(3'd5, 32'h5, 32'hFFFF_FFFD);
      #1 chk("flushd_index", 32'(bus.BranchIndexE), 32'h0);
      cmp_all("flushd");
      ex(3'd0, 32'h0, 32'h0);

      // Flags 10 behaves as a miss
      fetch(2'b10, 3'd4);
      tick(); tick();
      ex(3'd5, 32'h5, 32'hFFFF_FFFD);
      #1 chk("f10_code", 32'(bus.BranchE), 32'h1);
      chk("f10_index", 32'(bus.BranchIndexE), 32'h4);
      tick();

      // Asynchronous reset with a prediction in flight
      fetch(2'b11, 3'd5);
      ex(3'd0, 32'h0, 32'h0);
      tick(); tick();
      ex(3'd1, 32'h1, 32'h2);
      #1 chk("pre_rst_code", 32'(bus.BranchE), 32'h3);
      #2 CpuRst_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst_code", 32'(bus.BranchE), 32'h0);
      chk("async_rst_index", 32'(bus.BranchIndexE), 32'h0);
      chk("async_rst_bcnt", bus.BranchCnt, 32'h0);
      chk("async_rst_mcnt", bus.MissCnt, 32'h0);
      #1 CpuRst_n = 1'b1;
      ex(3'd1, 32'h1, 32'h1);
      #1 chk("post_rst_code", 32'(bus.BranchE), 32'h1);
      tick();

      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         a = $urandom();
         b = ($urandom_range(0, 3) == 0) ? a : $urandom();
         if ($urandom_range(0, 3) == 0) b = a ^ 32'h8000_0000;
         fetch(2'($urandom_range(0, 3)), IDX_W'($urandom_range(0, 7)));
         ctrl($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
         ex(3'($urandom_range(0, 7)), a, b);
         cmp_all("rand");
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX-stage counterpart of the fetch-side BTB/NPC logic.
- Carries the fetch-time prediction (BranchFlags, BranchIndex) through IF/ID and ID/EX registers and evaluates the actual branch condition in EX.
- Emits the 2-bit resolution code BranchE and BranchIndexE, which the NPC generator consumes the same cycle for redirect and BTB update.
- Optional performance counters track resolved and mispredicted branches.

Parameters:
- IDX_W, 3, BTB index width (8 entries)
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  core clock
- CpuRst_n  in  1  asynchronous active-low reset
- BranchFlags  in  2  fetch prediction; bit0 = BTB hit, bit1 = predict taken
- BranchIndex  in  IDX_W  BTB entry matched at fetch
- StallD  in  1  hold IF/ID copy
- FlushD  in  1  clear IF/ID copy
- StallE  in  1  hold ID/EX copy
- FlushE  in  1  clear ID/EX copy
- BranchTypeE  in  3  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BLTU, 5 BGE, 6 BGEU, 7 reserved (treated as none)
- Operand1E  in  32  rs1 value after forwarding
- Operand2E  in  32  rs2 value after forwarding
- BranchE  out  2  resolution code
- BranchIndexE  out  IDX_W  BTB index of the EX instruction
- BranchCnt  out  CNT_W  resolved branches (feature only)
- MissCnt  out  CNT_W  nonzero BranchE events (feature only)

Behaviour:
- Reset (CpuRst_n low, asynchronous): FlagsD, IdxD, FlagsE and IdxE clear to 0. BranchE = 00. BranchIndexE = 0. Counters = 0.
- IF/ID register, per rising edge:
  - FlushD clears it to 0.
  - Otherwise StallD holds it.
  - Otherwise it loads BranchFlags and BranchIndex.
  - Flush has priority over stall.
- ID/EX register: same rules using FlushE and StallE, loading from the IF/ID register.
- Taken, combinational from EX operands:
  - BEQ: equality.
  - BNE: inequality.
  - BLT / BGE: signed compare.
  - BLTU / BGEU: unsigned compare.
  - Types 0 and 7: never taken.
- Hit = FlagsE[0]. Pred = FlagsE[0] & FlagsE[1]. A flags value of 10 is treated as a miss.
- BranchE, combinational, zero latency from EX registers and operands:
  - Type none: 00.
  - Miss & taken: 01.
  - Hit & !Pred & taken: 10.
  - Hit & Pred & !taken: 11.
  - All other cases (correct prediction): 00.
- BranchIndexE = IdxE, always driven, including on a miss.
- BranchE is valid every cycle, including while StallE is asserted. The consumer gates on stalls.
- A flushed bubble has FlagsE = 00 and BranchTypeE = 0, so BranchE = 00.
- Reset mid-operation: in-flight predictions are discarded. The first post-reset branch resolves as a miss.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- Defined:
  - BranchCnt increments on each rising edge where BranchTypeE is in 1..6 and StallE = 0.
  - MissCnt increments under the same condition when BranchE != 00.
  - Both counters wrap modulo 2^CNT_W and are cleared only by reset.
- Undefined:
  - Counters are not instantiated.
  - BranchCnt and MissCnt are tied to 0.

Test Plan:
1. Reset: drive CpuRst_n = 0 mid-stream with nonzero flags in flight -> BranchE = 00, BranchIndexE = 0, counters 0, immediately (asynchronous).
2. BTB miss, taken: flags 00, BEQ, Operand1E = Operand2E = 0x5 after 2 clocks -> BranchE = 01; MissCnt 0 -> 1.
3. Hit, predict taken, not taken: flags 11, index 3, BLT, Operand1E = 0x1, Operand2E = 0xFFFFFFFF -> BranchE = 11, BranchIndexE = 3. With BLTU and the same operands -> BranchE = 00.
4. Hit, predict not taken, taken: flags 01, index 6, BNE, 0x2 vs 0x3 -> BranchE = 10, BranchIndexE = 6.
5. Flush and stall:
   - FlushE asserted with flags 01 arriving in ID/EX -> FlagsE = 00, BranchE = 00 for a miss-not-taken type.
   - StallE held for 3 cycles on a resolving branch -> BranchCnt increments once.
6. Simultaneous FlushD and StallD -> IF/ID cleared (flush wins); flags 10 with BGE taken -> BranchE = 01 (treated as miss).
